flash_sample_streamer: RTL and testbench



---
 rtl/flash_stream_pkg.sv | 16 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/flash_sample_streamer.sv | 123 ++++++++++++
 tb/tb_flash_sample_streamer.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_stream_pkg.sv
// Shared types and widths for the flash sample streamer.
// Imported by the streamer top and its sample FIFO.
package flash_stream_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;
  localparam int FLASH_AW = 23;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    PUSH_HI
  } streamer_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead sample FIFO: dout always reflects the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
  import flash_stream_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/flash_sample_streamer.sv
// Flash read master unpacking 32-bit words into a 16-bit sample stream.
// Define FLASH_STREAMER_ATTEN_EN to shift samples right by SHIFT.
module flash_sample_streamer
  import flash_stream_pkg::*;
#(
  parameter logic [FLASH_AW-1:0] START_ADDR = 23'h000000,
  parameter logic [FLASH_AW-1:0] END_ADDR   = 23'h100000,
  parameter int                  DEPTH      = 8,
  parameter int                  SHIFT      = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   flash_mem_read,
  output logic [FLASH_AW-1:0]    flash_mem_address,
  output logic [3:0]             flash_mem_byteenable,
  input  logic                   flash_mem_waitrequest,
  input  logic [WORD_W-1:0]      flash_mem_readdata,
  input  logic                   flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0]    sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   wrapped
);

  localparam int LW = $clog2(DEPTH) + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      SHIFT < 0 || SHIFT >= SAMPLE_W) begin : g_bad_cfg
    $error("flash_sample_streamer: bad DEPTH/SHIFT");
  end

  streamer_state_t       state;
  streamer_state_t       state_nx;
  logic [SAMPLE_W-1:0]   hi_q;
  logic [SAMPLE_W-1:0]   half;
  logic [SAMPLE_W-1:0]   push_data;
  logic                  push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  room;

  assign flash_mem_byteenable = 4'b1111;
  // Both halves of a word must fit before a read is issued
  assign room = (fifo_level <= LW'(DEPTH - 2)) & ~fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    push           = 1'b0;
    half           = flash_mem_readdata[15:0];
    flash_mem_read = 1'b0;
    unique case (state)
      IDLE: begin
        if (run && room) state_nx = REQ;
      end
      REQ: begin
        flash_mem_read = 1'b1;
        if (!flash_mem_waitrequest) state_nx = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          push     = 1'b1;
          state_nx = PUSH_HI;
        end
      end
      PUSH_HI: begin
        push     = 1'b1;
        half     = hi_q;
        state_nx = IDLE;
      end
    endcase
  end

`ifdef FLASH_STREAMER_ATTEN_EN
  assign push_data = SAMPLE_W'($signed(half) >>> SHIFT);
`else
  assign push_data = half;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q              <= '0;
      flash_mem_address <= START_ADDR;
      wrapped           <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      if (state == WAIT_DATA && flash_mem_readdatavalid)
        hi_q <= flash_mem_readdata[31:16];
      if (state == PUSH_HI) begin
        if (flash_mem_address == END_ADDR) begin
          flash_mem_address <= START_ADDR;
          wrapped           <= 1'b1;
        end else begin
          flash_mem_address <= flash_mem_address + 1'b1;
        end
      end
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .pop   (sample_valid & sample_ready),
    .dout  (sample_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign sample_valid = ~fifo_empty;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Bench for flash_sample_streamer: flash responder, sample scoreboard.
// Build with FLASH_STREAMER_ATTEN_EN to exercise attenuation.
module tb_flash_sample_streamer;

  localparam logic [22:0] START = 23'h000000;
  localparam logic [22:0] ENDA  = 23'h000003;
  localparam int          DEPTH = 8;
  localparam int          SHIFT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  fifo_level;
  logic        wrapped;

  flash_sample_streamer #(
    .START_ADDR (START),
    .END_ADDR   (ENDA),
    .DEPTH      (DEPTH),
    .SHIFT      (SHIFT)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .run                     (run),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .sample_data             (sample_data),
    .sample_valid            (sample_valid),
    .sample_ready            (sample_ready),
    .fifo_level              (fifo_level),
    .wrapped                 (wrapped)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [4];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          acc_addr_q[$];
  int          acc_cnt = 0;
  int          end_cnt = 0;
  int          wrap_cnt = 0;
  logic [22:0] exp_addr = START;
  bit          manual = 1'b0;
  bit          rand_wait = 1'b0;
  int          max_lat = 0;
  int          stall_cnt = 0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [22:0] pend_a;

  // Expected sample: floor(x / 2^SHIFT) when attenuating
  function automatic logic [15:0] ref_sample(input logic [15:0] h);
    int v;
    int d;
    v = int'($signed(h));
    d = 1 << SHIFT;
`ifdef FLASH_STREAMER_ATTEN_EN
    if (v >= 0) v = v / d;
    else        v = -((-v + d - 1) / d);
`endif
    return v[15:0];
  endfunction

  // Avalon slave model; every accepted read feeds the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!manual) begin
        flash_mem_readdatavalid = 1'b0;
        if (pend) begin
          if (lat == 0) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = mem[pend_a[1:0]];
            pend                    = 1'b0;
          end else begin
            lat--;
          end
        end else begin
          flash_mem_readdata = $urandom;
        end
        if (flash_mem_read && rst_n) begin
          if (stall_cnt > 0) begin
            flash_mem_waitrequest = 1'b1;
            stall_cnt--;
          end else begin
            flash_mem_waitrequest =
              rand_wait && ($urandom_range(0, 2) == 0);
          end
          if (!flash_mem_waitrequest) begin
            n_cmp++;
            if (flash_mem_address !== exp_addr) begin
              n_bad++;
              $display("FAIL read_addr: got %h want %h",
                       flash_mem_address, exp_addr);
            end
            acc_cnt++;
            acc_addr_q.push_back(int'(flash_mem_address));
            pend_a = flash_mem_address;
            exp_q.push_back(ref_sample(mem[pend_a[1:0]][15:0]));
            exp_q.push_back(ref_sample(mem[pend_a[1:0]][31:16]));
            if (exp_addr == ENDA) begin
              end_cnt++;
              exp_addr = START;
            end else begin
              exp_addr = exp_addr + 1'b1;
            end
            pend = 1'b1;
            lat  = $urandom_range(0, max_lat);
          end
        end else begin
          flash_mem_waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Consumer-side scoreboard and wrapped pulse-width check
  initial begin
    bit wrap_prev;
    wrap_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (wrapped) begin
          wrap_cnt++;
          n_cmp++;
          if (wrap_prev) begin
            n_bad++;
            $display("FAIL wrapped_width: high 2 cycles, want 1");
          end
        end
        wrap_prev = wrapped;
        if (sample_valid && sample_ready) begin
          got_q.push_back(sample_data);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sample: got %h want none", sample_data);
          end else if (sample_data !== exp_q[0]) begin
            n_bad++;
            $display("FAIL sample: got %h want %h",
                     sample_data, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end else begin
        wrap_prev = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    run = 1'b0;
    sample_ready = 1'b1;
    for (int i = 0; i < 2000 && quiet < 6; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pend && !flash_mem_read &&
          !sample_valid)
        quiet++;
      else
        quiet = 0;
    end
    n_cmp++;
    if (quiet < 6) begin
      n_bad++;
      $display("FAIL drain: %0d samples left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0;
    sample_ready = 1'b0;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp += 6;
    if (flash_mem_read !== 1'b0) begin
      n_bad++; $display("FAIL rst_read: got %b want 0", flash_mem_read);
    end
    if (flash_mem_address !== START) begin
      n_bad++; $display("FAIL rst_addr: got %h want %h",
                        flash_mem_address, START);
    end
    if (sample_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", sample_valid);
    end
    if (fifo_level !== 4'd0) begin
      n_bad++; $display("FAIL rst_level: got %0d want 0", fifo_level);
    end
    if (wrapped !== 1'b0) begin
      n_bad++; $display("FAIL rst_wrapped: got %b want 0", wrapped);
    end
    if (flash_mem_byteenable !== 4'hF) begin
      n_bad++; $display("FAIL byteenable: got %h want f",
                        flash_mem_byteenable);
    end
  endtask

  task automatic test_basic_order();
    logic [15:0] want [4];
    int t;
    mem[0] = 32'hBBBB_AAAA;
    mem[1] = 32'hDDDD_CCCC;
    mem[2] = $urandom;
    mem[3] = $urandom;
    want[0] = ref_sample(16'hAAAA);
    want[1] = ref_sample(16'hBBBB);
    want[2] = ref_sample(16'hCCCC);
    want[3] = ref_sample(16'hDDDD);
    got_q.delete();
    acc_addr_q.delete();
    rand_wait = 1'b0;
    max_lat = 2;
    sample_ready = 1'b1;
    run = 1'b1;
    t = 0;
    while (acc_cnt < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    wait_idle();
    n_cmp++;
    if (acc_addr_q.size() < 3 || got_q.size() < 4) begin
      n_bad++;
      $display("FAIL basic_count: got %0d reads want 3",
               acc_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (acc_addr_q[i] != i) begin
          n_bad++;
          $display("FAIL basic_addr%0d: got %0d want %0d",
                   i, acc_addr_q[i], i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_q[i] !== want[i]) begin
          n_bad++;
          $display("FAIL basic_sample%0d: got %h want %h",
                   i, got_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_wait_stall();
    logic [22:0] a0;
    int acc0;
    int t;
    bit seen;
    rand_wait = 1'b0;
    stall_cnt = 5;
    acc0 = acc_cnt;
    run = 1'b1;
    seen = 1'b0;
    for (t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      seen = flash_mem_read;
    end
    run = 1'b0;
    a0 = flash_mem_address;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL stall_start: got no read want read");
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (flash_mem_read !== 1'b1 || flash_mem_address !== a0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got read=%b addr=%h want 1/%h",
                 i, flash_mem_read, flash_mem_address, a0);
      end
    end
    wait_idle();
    n_cmp++;
    if (acc_cnt - acc0 != 1) begin
      n_bad++;
      $display("FAIL stall_accepts: got %0d want 1", acc_cnt - acc0);
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    int extra;
    bit seen;
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    rand_wait = 1'b0;
    max_lat = 1;
    acc0 = acc_cnt;
    sample_ready = 1'b0;
    run = 1'b1;
    repeat (80) @(negedge clk);
    n_cmp += 2;
    if (fifo_level !== 4'd8) begin
      n_bad++; $display("FAIL bp_full: got %0d want 8", fifo_level);
    end
    if (acc_cnt - acc0 != 4) begin
      n_bad++; $display("FAIL bp_words: got %0d want 4", acc_cnt - acc0);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (flash_mem_read) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL bp_read_full: got %0d want 0", extra);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 4'd7) begin
      n_bad++; $display("FAIL bp_level7: got %0d want 7", fifo_level);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (flash_mem_read) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL bp_read_7: got %0d want 0", extra);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (flash_mem_read) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL bp_resume: got no read want read at 6");
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    int w0;
    int e0;
    int t;
    int found;
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    acc_addr_q.delete();
    rand_wait = 1'b1;
    max_lat = 2;
    w0 = wrap_cnt;
    e0 = end_cnt;
    run = 1'b1;
    t = 0;
    while (end_cnt - e0 < 2 && t < 400) begin
      @(negedge clk);
      t++;
    end
    wait_idle();
    n_cmp++;
    if (wrap_cnt - w0 != end_cnt - e0 || end_cnt - e0 < 2) begin
      n_bad++;
      $display("FAIL wrap_pulses: got %0d want %0d (>=2)",
               wrap_cnt - w0, end_cnt - e0);
    end
    found = 0;
    for (int i = 0; i + 1 < acc_addr_q.size(); i++) begin
      if (acc_addr_q[i] == int'(ENDA)) begin
        found++;
        n_cmp++;
        if (acc_addr_q[i+1] != int'(START)) begin
          n_bad++;
          $display("FAIL wrap_addr: got %0d want %0d",
                   acc_addr_q[i+1], START);
        end
      end
    end
    n_cmp++;
    if (found == 0) begin
      n_bad++; $display("FAIL wrap_seen: got 0 wraps want >=1");
    end
  endtask

`ifdef FLASH_STREAMER_ATTEN_EN
  task automatic test_atten();
    int acc0;
    int t;
    int n;
    mem[exp_addr[1:0]] = 32'h0040_FFC0;
    got_q.delete();
    rand_wait = 1'b0;
    acc0 = acc_cnt;
    run = 1'b1;
    t = 0;
    while (acc_cnt == acc0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    run = 1'b0;
    wait_idle();
    n = got_q.size();
    n_cmp++;
    if (n < 2) begin
      n_bad++; $display("FAIL atten_count: got %0d want >=2", n);
    end else begin
      n_cmp++;
      if (got_q[n-2] !== 16'hFFFF || got_q[n-1] !== 16'h0001) begin
        n_bad++;
        $display("FAIL atten: got %h %h want ffff 0001",
                 got_q[n-2], got_q[n-1]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    rand_wait = 1'b1;
    max_lat = 3;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      sample_ready = ($urandom_range(0, 3) != 0);
      run = ($urandom_range(0, 7) != 0);
    end
    wait_idle();
    n_cmp++;
    if (fifo_level !== 4'd0) begin
      n_bad++; $display("FAIL rand_level: got %0d want 0", fifo_level);
    end
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    manual = 1'b1;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    sample_ready = 1'b1;
    run = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = flash_mem_read;
    end
    run = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!seen || flash_mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_setup: got seen=%b read=%b want 1/0",
               seen, flash_mem_read);
    end
    rst_n = 1'b0;
    exp_q.delete();
    exp_addr = START;
    pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    flash_mem_readdata = 32'h1234_5678;
    flash_mem_readdatavalid = 1'b1;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp += 3;
    if (sample_valid !== 1'b0 || fifo_level !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_fifo: got valid=%b level=%0d want 0/0",
               sample_valid, fifo_level);
    end
    if (flash_mem_address !== START) begin
      n_bad++; $display("FAIL mid_addr: got %h want %h",
                        flash_mem_address, START);
    end
    if (flash_mem_read !== 1'b0) begin
      n_bad++; $display("FAIL mid_read: got %b want 0", flash_mem_read);
    end
    manual = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_basic_order();
    test_wait_stall();
    test_backpressure();
    test_wrap();
`ifdef FLASH_STREAMER_ATTEN_EN
    test_atten();
`endif
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
